// File: rtl/d_factor_pkg.sv
// Shared constants and the D-factor table for the adaptive-threshold D_Factor path.
// D factors are unsigned Q4.12: 1.0 at index 0 up to 3.0 at index 32, in steps of 1/16.
package d_factor_pkg;

  localparam int D_FRAC  = 12;
  localparam int DF_W    = 16;
  localparam int IDX_W   = 6;
  localparam int IDX_MAX = 32;

  // Out-of-range addresses read as the last entry so the table stays monotonic.
  function automatic logic [DF_W-1:0] d_lut(input logic [IDX_W-1:0] k);
    logic [IDX_W-1:0] kc;
    kc = (k > IDX_W'(IDX_MAX)) ? IDX_W'(IDX_MAX) : k;
    return DF_W'(4096 + 256 * int'(kc));
  endfunction

endpackage

// File: rtl/d_factor_lut.sv
// Registered 33-entry D-factor ROM: the averaged index is in, and the Q4.12 factor is out one edge later.
module d_factor_lut
  import d_factor_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W-1:0] i_addr,
  output logic [DF_W-1:0]  o_dfac
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) o_dfac <= '0;
    else       o_dfac <= d_lut(i_addr);
  end

endmodule

// File: rtl/d_factor_threshold_gen.sv
// Averages encoder indices over 2^AVG_LOG2 samples and maps the average through the D-factor table.
// The result is scaled by the noise floor and emitted as a saturated threshold, with a 4-stage valid chain.
module d_factor_threshold_gen
  import d_factor_pkg::*;
#(
  parameter int               AVG_LOG2 = 2,
  parameter int               NOISE_W  = 24,
  parameter int               THR_W    = 24,
  parameter logic [THR_W-1:0] THR_INIT = {THR_W{1'b1}}
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic [5:0]         index_in,
  input  logic               index_dv,
  input  logic [NOISE_W-1:0] noise_in,
  input  logic               noise_dv,
  output logic [THR_W-1:0]   threshold_out,
  output logic               threshold_dv,
  output logic [5:0]         avg_index_out
);

  localparam int ACC_W  = IDX_W + AVG_LOG2;
  localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int PROD_W = NOISE_W + DF_W;
  localparam int SHF_W  = PROD_W - D_FRAC;

  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [NOISE_W-1:0] r_noise;
  logic [NOISE_W-1:0] r_noise_snap;
  logic [IDX_W-1:0]   r_avg;
  logic [PROD_W-1:0]  r_prod;
  logic [3:1]         r_vld_pipe;

  logic [IDX_W-1:0]   w_idx;
  logic [ACC_W-1:0]   w_sum;
  logic [IDX_W-1:0]   w_avg;
  logic               w_last;
  logic               w_fire;
  logic               w_out_en;
  logic [DF_W-1:0]    w_dfac;
  logic [SHF_W-1:0]   w_shf;
  logic [THR_W-1:0]   w_thr;

  assign w_idx  = (index_in > 6'(IDX_MAX)) ? 6'(IDX_MAX) : index_in;
  assign w_sum  = r_acc + ACC_W'(w_idx);
  assign w_avg  = IDX_W'(w_sum >> AVG_LOG2);
  // With AVG_LOG2=0 the counter is pinned at 0, so every sample closes a block.
  assign w_last = (r_cnt == CNT_W'((1 << AVG_LOG2) - 1));
  assign w_fire = index_dv & ~clear & w_last;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (clear) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (index_dv) begin
      if (w_last) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)         r_noise <= '0;
    else if (noise_dv) r_noise <= noise_in;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)      r_vld_pipe <= '0;
    else if (clear) r_vld_pipe <= '0;
    else            r_vld_pipe <= {r_vld_pipe[2:1], w_fire};
  end

  // S1: the debug output and the table address move together. Clear leaves both untouched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_avg         <= '0;
      avg_index_out <= '0;
    end else if (w_fire) begin
      r_avg         <= w_avg;
      avg_index_out <= w_avg;
    end
  end

  // S2: the noise snapshot aligns with the table read, so a noise_dv on this edge is seen only by later blocks.
  d_factor_lut u_lut (
    .clock  (clock),
    .reset  (reset),
    .i_addr (r_avg),
    .o_dfac (w_dfac)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_noise_snap <= '0;
    else       r_noise_snap <= r_noise;
  end

  // S3
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_prod <= '0;
    else       r_prod <= PROD_W'(r_noise_snap) * PROD_W'(w_dfac);
  end

  // S4: floor-shift out the fraction, then saturate.
  assign w_shf = SHF_W'(r_prod >> D_FRAC);

  generate
    if (SHF_W > THR_W) begin : g_sat
      assign w_thr = (|w_shf[SHF_W-1:THR_W]) ? {THR_W{1'b1}} : w_shf[THR_W-1:0];
    end else begin : g_nosat
      assign w_thr = THR_W'(w_shf);
    end
  endgenerate

  assign w_out_en = r_vld_pipe[3] & ~clear;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      threshold_out <= THR_INIT;
      threshold_dv  <= 1'b0;
    end else begin
      threshold_dv <= w_out_en;
      if (w_out_en) threshold_out <= w_thr;
    end
  end

endmodule
